uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the single-buffer 8N1 receiver.
- Configurable data width, clock divider and optional parity.
- Input synchroniser, framing/parity/overrun error detection.
- Receive FIFO drained by the CPU with a pop strobe; sits between the board RX pin and the CPU's I/O read path.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- CLK_DIV, 10, clk cycles per bit (>=4).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- FIFO_DEPTH, 4, entries; power of two, >=2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- uart_in  in  1  serial line, asynchronous, idle high.
- cpu_end_read  in  1  pop strobe, one clk high = consume head entry.
- err_clr  in  1  clears all sticky error flags.
- uart_to_cpu_buf  out  DATA_BITS  FIFO head (first-word fall-through); 0 when empty.
- rx_valid  out  1  FIFO non-empty.
- read_int  out  1  one-cycle pulse per byte pushed.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: good frame dropped, FIFO full.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state:
  - FSM in IDLE, FIFO empty, fifo_count=0, uart_to_cpu_buf=0.
  - read_int=0, all error flags 0, divider=0, synchroniser flops=1.
  - Reset mid-frame discards the partial frame.
- Synchroniser: 2-flop synchroniser on uart_in; all logic uses the synchronised line (rx_s). Adds 2 cycles of latency.
- Divider: counts 0..CLK_DIV-1 and wraps. "tick" = cycle where count==CLK_DIV-1. On a start detect it is loaded with CLK_DIV/2 so ticks land mid-bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: rx_s==0 -> START, divider loaded.
  - START, on tick: rx_s==0 -> DATA with bit_cnt=0; else -> IDLE (glitch rejected, nothing flagged).
  - DATA, on tick: shift right, MSB=rx_s. At bit_cnt==DATA_BITS-1 -> PARITY if PARITY_EN, else STOP. Otherwise bit_cnt++.
  - PARITY, on tick: compute mismatch = (XOR of data ^ rx_s) != PARITY_ODD; latch mismatch -> STOP.
  - STOP, on tick:
    - rx_s==1, no mismatch: push data if not full -> IDLE.
    - rx_s==1, no mismatch, FIFO full at that edge: set overrun, discard, -> IDLE.
    - rx_s==1, mismatch: set parity_err, discard, -> IDLE.
    - rx_s==0: set frame_err, discard, -> BREAK_WAIT.
  - BREAK_WAIT: stays until rx_s==1, then -> IDLE. Line breaks generate no further errors.
- Timing (CLK_DIV=10): first rx_s low at cycle T. Start sampled T+5, data bit k at T+15+10k, stop at T+5+10*(DATA_BITS+1+PARITY_EN). The push happens on that edge; rx_valid and read_int are high the next cycle; read_int drops after one cycle.
- FIFO rules:
  - Pop when empty is ignored.
  - Push and pop in the same cycle: both occur (also legal when full, count unchanged, no overrun).
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved.
- Error flags: err_clr clears the flags. If an error sets in the same cycle as err_clr, the set wins. Errors never block reception of later frames.

Decomposition:
- Package uart_pkg: FSM state encoding, parity-mode constants, a function for the divider half-load value.
- Sub-module sync_fifo (params WIDTH, DEPTH): push, pop, head, count, full, empty. Reusable for a future TX path.
- The divider stays inline; it is too small to separate.

Test Plan:
- Defaults; send 0xA5 8N1, no pop -> read_int pulses once at T+96; rx_valid=1, uart_to_cpu_buf=0xA5, fifo_count=1. cpu_end_read one cycle -> rx_valid=0, buf=0.
- Low pulse of 3 clk on idle line -> START then IDLE; no read_int, no flags, fifo_count=0. A valid 0x3C sent right after is received correctly.
- Send 0x55 with stop bit 0, line low 30 further clk -> frame_err=1, no push, FSM in BREAK_WAIT. Line high, then 0x12 -> received 0x12; frame_err still 1 until err_clr.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err=1, no push. Resend with parity 1 -> 0x07 pushed, read_int pulse.
- Send 0x01..0x05 back-to-back, no pops -> fifo_count=4, overrun=1. Pops return 0x01,0x02,0x03,0x04. Overrun remains set in the same cycle as an err_clr coinciding with a new overrun.
- rst asserted mid-DATA of a frame -> all outputs at reset values next cycle. The next full frame 0xC3 is received. FIFO full with a pop on the push edge -> count stays 4, overrun stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding, parity modes and
// the divider half-bit load used to centre sampling on each bit.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    function automatic int unsigned div_half_load(input int unsigned clk_div);
        return clk_div / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; head reads 0 when empty.
// A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/divider/parity, sticky error flags and
// a receive FIFO that the CPU drains with a one-cycle pop strobe.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 10,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_in,
    input  logic                          cpu_end_read,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          uart_to_cpu_buf,
    output logic                          rx_valid,
    output logic                          read_int,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(div_half_load(CLK_DIV));
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

    logic [2:0]           state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 mismatch_q, mismatch_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 read_int_q, read_int_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s, tick, push_req, set_frame, set_parity, set_overrun;
    logic                 fifo_full, fifo_empty;

    assign rx_s = sync2_q;
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mismatch_d  = mismatch_q;
        sync1_d     = uart_in;
        sync2_d     = sync1_q;
        push_req    = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            ST_IDLE: if (!rx_s) begin
                state_d    = ST_START;
                div_d      = DIV_HALF;
                mismatch_d = 1'b0;
            end
            ST_START: if (tick) begin
                state_d   = rx_s ? ST_IDLE : ST_DATA;
                bit_cnt_d = '0;
            end
            ST_DATA: if (tick) begin
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: if (tick) begin
                mismatch_d = ((^shift_q) ^ rx_s) != PAR_MODE;
                state_d    = ST_STOP;
            end
            ST_STOP: if (tick) begin
                if (!rx_s) begin
                    set_frame = 1'b1;
                    state_d   = ST_BREAK_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    if (mismatch_q) begin
                        set_parity = 1'b1;
                    end else if (fifo_full && !cpu_end_read) begin
                        set_overrun = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
            end
            ST_BREAK_WAIT: if (rx_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        read_int_d   = push_req;
        // A flag being set in the same cycle as err_clr stays set.
        frame_err_d  = (frame_err_q  && !err_clr) || set_frame;
        parity_err_d = (parity_err_q && !err_clr) || set_parity;
        overrun_d    = (overrun_q    && !err_clr) || set_overrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            mismatch_q   <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            read_int_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            mismatch_q   <= mismatch_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            read_int_q   <= read_int_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (cpu_end_read),
        .wdata (shift_q),
        .head  (uart_to_cpu_buf),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign read_int   = read_int_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an even-parity instance
// driven with hand-built frames, checked against hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       uart_a = 1'b1, cpu_a = 1'b0, clr_a = 1'b0;
    logic [7:0] buf_a;
    logic       valid_a, ri_a, fe_a, pe_a, ov_a;
    logic [2:0] cnt_a;

    logic       uart_b = 1'b1, cpu_b = 1'b0, clr_b = 1'b0;
    logic [7:0] buf_b;
    logic       valid_b, ri_b, fe_b, pe_b, ov_b;
    logic [2:0] cnt_b;

    uart_rx_fifo dut_a (
        .clk(clk), .rst(rst), .uart_in(uart_a), .cpu_end_read(cpu_a), .err_clr(clr_a),
        .uart_to_cpu_buf(buf_a), .rx_valid(valid_a), .read_int(ri_a), .fifo_count(cnt_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .uart_in(uart_b), .cpu_end_read(cpu_b), .err_clr(clr_b),
        .uart_to_cpu_buf(buf_b), .rx_valid(valid_b), .read_int(ri_b), .fifo_count(cnt_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses_a = 0, pulses_b = 0;
    int ri_cyc_a = -1, ri_cyc_b = -1;
    int c0, p0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ri_a) begin pulses_a++; ri_cyc_a = cyc; end
        if (ri_b) begin pulses_b++; ri_cyc_b = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives frame bits LSB first, CLK_DIV=10 cycles each; called at posedge+1.
    task automatic send(input logic sel, input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel) uart_b = frame[i];
            else     uart_a = frame[i];
            repeat (10) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_a();
        cpu_a = 1'b1;
        @(posedge clk); #1;
        cpu_a = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_buf",   32'(buf_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_count", 32'(cnt_a), 32'h0);
        chk("rst_ri",    32'(ri_a), 32'h0);
        chk("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'h0);
        chk("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));

        // 0xA5 8N1: read_int two sync cycles plus T+96 after the line drops
        c0 = cyc;
        send(1'b0, 11'({1'b1, 8'hA5, 1'b0}), 10);
        chk("a5_pulses", 32'(pulses_a), 32'd1);
        chk("a5_ri_cyc", 32'(ri_cyc_a), 32'(c0 + 98));
        chk("a5_valid",  32'(valid_a), 32'h1);
        chk("a5_buf",    32'(buf_a), 32'hA5);
        chk("a5_count",  32'(cnt_a), 32'h1);
        pop_a();
        chk("a5_pop_valid", 32'(valid_a), 32'h0);
        chk("a5_pop_buf",   32'(buf_a), 32'h0);

        // Three-cycle glitch is rejected in START
        uart_a = 1'b0;
        repeat (3) @(posedge clk); #1;
        uart_a = 1'b1;
        chk("glitch_start", 32'(dut_a.state_q), 32'(ST_START));
        repeat (20) @(posedge clk); #1;
        chk("glitch_idle",   32'(dut_a.state_q), 32'(ST_IDLE));
        chk("glitch_pulses", 32'(pulses_a), 32'd1);
        chk("glitch_count",  32'(cnt_a), 32'h0);
        chk("glitch_flags",  32'({fe_a, pe_a, ov_a}), 32'h0);
        send(1'b0, 11'({1'b1, 8'h3C, 1'b0}), 10);
        chk("3c_buf", 32'(buf_a), 32'h3C);
        pop_a();

        // 0x55 with a low stop bit, then a held break
        send(1'b0, 11'({1'b0, 8'h55, 1'b0}), 10);
        repeat (30) @(posedge clk); #1;
        chk("brk_fe",    32'(fe_a), 32'h1);
        chk("brk_count", 32'(cnt_a), 32'h0);
        chk("brk_state", 32'(dut_a.state_q), 32'(ST_BREAK_WAIT));
        uart_a = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("brk_idle", 32'(dut_a.state_q), 32'(ST_IDLE));
        send(1'b0, 11'({1'b1, 8'h12, 1'b0}), 10);
        chk("12_buf",    32'(buf_a), 32'h12);
        chk("12_fe_sticky", 32'(fe_a), 32'h1);
        pop_a();
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("fe_cleared", 32'(fe_a), 32'h0);

        // Even parity: 0x07 has three ones so the correct parity bit is 1
        send(1'b1, 11'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        chk("par_bad_pe",     32'(pe_b), 32'h1);
        chk("par_bad_count",  32'(cnt_b), 32'h0);
        chk("par_bad_pulses", 32'(pulses_b), 32'd0);
        c0 = cyc;
        send(1'b1, 11'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        chk("par_ok_buf",    32'(buf_b), 32'h07);
        chk("par_ok_pulses", 32'(pulses_b), 32'd1);
        chk("par_ok_ri_cyc", 32'(ri_cyc_b), 32'(c0 + 108));
        chk("par_pe_sticky", 32'(pe_b), 32'h1);

        // Five frames into a four-entry FIFO
        p0 = pulses_a;
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 11'({1'b1, 8'(i), 1'b0}), 10);
        end
        chk("ovr_count",  32'(cnt_a), 32'h4);
        chk("ovr_flag",   32'(ov_a), 32'h1);
        chk("ovr_pulses", 32'(pulses_a), 32'(p0 + 4));
        c0 = cyc;
        fork
            send(1'b0, 11'({1'b1, 8'h06, 1'b0}), 10);
            begin
                repeat (97) @(posedge clk); #1;
                clr_a = 1'b1;
                @(posedge clk); #1;
                clr_a = 1'b0;
                chk("ovr_set_wins", 32'(ov_a), 32'h1);
            end
        join
        chk("ovr_drop_count",  32'(cnt_a), 32'h4);
        chk("ovr_drop_pulses", 32'(pulses_a), 32'(p0 + 4));
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("ovr_cleared", 32'(ov_a), 32'h0);
        chk("ovr_head1", 32'(buf_a), 32'h01); pop_a();
        chk("ovr_head2", 32'(buf_a), 32'h02); pop_a();
        chk("ovr_head3", 32'(buf_a), 32'h03); pop_a();
        chk("ovr_head4", 32'(buf_a), 32'h04);

        // Reset mid-DATA of an all-ones frame, so no false start follows
        c0 = cyc;
        fork
            send(1'b0, 11'({1'b1, 8'hFF, 1'b0}), 10);
            begin
                repeat (40) @(posedge clk); #1;
                chk("mid_state", 32'(dut_a.state_q), 32'(ST_DATA));
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("mrst_count", 32'(cnt_a), 32'h0);
                chk("mrst_valid", 32'(valid_a), 32'h0);
                chk("mrst_buf",   32'(buf_a), 32'h0);
                chk("mrst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
                chk("mrst_div",   32'(dut_a.div_q), 32'h0);
                chk("mrst_pe_b",  32'(pe_b), 32'h0);
                chk("mrst_cnt_b", 32'(cnt_b), 32'h0);
            end
        join
        chk("mrst_nopush", 32'(cnt_a), 32'h0);
        send(1'b0, 11'({1'b1, 8'hC3, 1'b0}), 10);
        chk("c3_buf",   32'(buf_a), 32'hC3);
        chk("c3_count", 32'(cnt_a), 32'h1);
        pop_a();

        // Full FIFO with a pop on the push edge: push accepted, no overrun
        send(1'b0, 11'({1'b1, 8'h11, 1'b0}), 10);
        send(1'b0, 11'({1'b1, 8'h22, 1'b0}), 10);
        send(1'b0, 11'({1'b1, 8'h33, 1'b0}), 10);
        send(1'b0, 11'({1'b1, 8'h44, 1'b0}), 10);
        chk("full_count", 32'(cnt_a), 32'h4);
        c0 = cyc;
        fork
            send(1'b0, 11'({1'b1, 8'h55, 1'b0}), 10);
            begin
                repeat (97) @(posedge clk); #1;
                cpu_a = 1'b1;
                @(posedge clk); #1;
                cpu_a = 1'b0;
                chk("pp_count", 32'(cnt_a), 32'h4);
                chk("pp_ovr",   32'(ov_a), 32'h0);
                chk("pp_head",  32'(buf_a), 32'h22);
            end
        join
        chk("pp_ri_cyc", 32'(ri_cyc_a), 32'(c0 + 98));
        chk("pp_q1", 32'(buf_a), 32'h22); pop_a();
        chk("pp_q2", 32'(buf_a), 32'h33); pop_a();
        chk("pp_q3", 32'(buf_a), 32'h44); pop_a();
        chk("pp_q4", 32'(buf_a), 32'h55); pop_a();
        chk("pp_empty_count", 32'(cnt_a), 32'h0);
        pop_a();
        chk("pop_empty_count", 32'(cnt_a), 32'h0);
        chk("pop_empty_valid", 32'(valid_a), 32'h0);
        chk("pop_empty_buf",   32'(buf_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
